// File: rtl/wb_arb.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant,
// owner abort on cyc drop, and a per-transfer ack timeout that errors the owner.
module wb_arb #(
  parameter int ADDR_LEN = 39,
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 255,
  parameter int TO_W     = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_LEN-1:0]     m0_adr_i,
  input  logic [DATA_LEN-1:0]     m0_dat_i,
  input  logic [DATA_LEN/8-1:0]   m0_sel_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic [DATA_LEN-1:0]     m0_dat_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_LEN-1:0]     m1_adr_i,
  input  logic [DATA_LEN-1:0]     m1_dat_i,
  input  logic [DATA_LEN/8-1:0]   m1_sel_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [DATA_LEN-1:0]     m1_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_LEN-1:0]     s_adr_o,
  output logic [DATA_LEN-1:0]     s_dat_o,
  output logic [DATA_LEN/8-1:0]   s_sel_o,
  input  logic                    s_ack_i,
  input  logic [DATA_LEN-1:0]     s_dat_i,
  output logic                    busy_o,
  output logic                    grant_o
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic            state;
  logic            grant;
  logic            last;
  logic [TO_W-1:0] cnt;

  logic busy;
  logic own_cyc;
  logic own_stb;
  logic req_any;
  logic winner;
  logic to_hit;
  logic exit_busy;
  logic ack_any;
  logic err_any;

  always_comb begin
    busy      = (state == ST_BUSY);
    own_cyc   = grant ? m1_cyc_i : m0_cyc_i;
    own_stb   = grant ? m1_stb_i : m0_stb_i;
    req_any   = m0_cyc_i | m1_cyc_i;
    // On contention the master that did not own the bus last time wins.
    winner    = (m0_cyc_i & m1_cyc_i) ? ~last : m1_cyc_i;
    to_hit    = (cnt == TO_LAST);
    exit_busy = s_ack_i | ~own_cyc | to_hit;
    ack_any   = busy & s_ack_i;
    err_any   = busy & ~s_ack_i & own_cyc & to_hit;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            state <= ST_BUSY;
            grant <= winner;
            cnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (exit_busy) begin
            state <= ST_IDLE;
            last  <= grant;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Slave side is forced to zero outside BUSY; s_ack_i never feeds these.
  always_comb begin
    s_cyc_o = busy & own_cyc;
    s_stb_o = busy & own_stb;
    s_we_o  = busy & (grant ? m1_we_i : m0_we_i);
    s_adr_o = busy ? (grant ? m1_adr_i : m0_adr_i) : '0;
    s_dat_o = busy ? (grant ? m1_dat_i : m0_dat_i) : '0;
    s_sel_o = busy ? (grant ? m1_sel_i : m0_sel_i) : '0;
  end

  assign m0_ack_o = ack_any & ~grant;
  assign m1_ack_o = ack_any & grant;
  assign m0_err_o = err_any & ~grant;
  assign m1_err_o = err_any & grant;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign busy_o   = busy;
  assign grant_o  = grant;

endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: expected master responses are queued when the
// slave is told to respond and checked by a monitor when an ack/err appears.
module tb_wb_arb;

  localparam int AL = 39;
  localparam int DL = 32;
  localparam int SL = DL / 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AL-1:0] m0_adr_i;
  logic [DL-1:0] m0_dat_i;
  logic [SL-1:0] m0_sel_i;
  logic          m0_ack_o, m0_err_o;
  logic [DL-1:0] m0_dat_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AL-1:0] m1_adr_i;
  logic [DL-1:0] m1_dat_i;
  logic [SL-1:0] m1_sel_i;
  logic          m1_ack_o, m1_err_o;
  logic [DL-1:0] m1_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AL-1:0] s_adr_o;
  logic [DL-1:0] s_dat_o;
  logic [SL-1:0] s_sel_o;
  logic          s_ack_i;
  logic [DL-1:0] s_dat_i;
  logic          busy_o, grant_o;

  wb_arb #(.ADDR_LEN(AL), .DATA_LEN(DL), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .busy_o(busy_o), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          master;
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drop_masters();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
  endtask

  // Response monitor: every ack/err must match the oldest queued expectation.
  always @(negedge clk) begin
    int          who;
    bit          er;
    logic [31:0] d;
    exp_t        e;
    if (rstn && (m0_ack_o || m1_ack_o || m0_err_o || m1_err_o)) begin
      who = (m1_ack_o || m1_err_o) ? 1 : 0;
      er  = m0_err_o || m1_err_o;
      d   = (who == 1) ? m1_dat_o : m0_dat_o;
      chk("sb_single_owner", {62'd0, m0_ack_o | m0_err_o, m1_ack_o | m1_err_o},
          (who == 1) ? 64'd1 : 64'd2);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL sb_unexpected: observed master=%0d err=%0b expected=no response", who, er);
      end else begin
        e = sb.pop_front();
        chk("sb_master", who, e.master);
        chk("sb_kind_err", er, e.is_err);
        if (!e.is_err) chk("sb_rdata", d, e.data);
      end
    end
  end

  initial begin
    #100000;
    $error("FAIL watchdog: observed=time limit expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int owner;
    rstn = 1'b0;
    drop_masters();
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;

    #2;
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_resp", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    chk("rst_s_adr", s_adr_o, 0);
    #10 rstn = 1'b1;

    // m0 single read, slave acks two cycles after s_cyc_o rises
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 39'h0_1000_0000; m0_sel_i = 4'hF;
    look(); chk("t1_arb_latency", s_cyc_o, 0);
    step(); look();
    chk("t1_s_cyc", s_cyc_o, 1);
    chk("t1_grant", grant_o, 0);
    chk("t1_s_adr", s_adr_o, 39'h0_1000_0000);
    chk("t1_s_sel", s_sel_o, 4'hF);
    step(); look(); chk("t1_no_early_ack", m0_ack_o, 0);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    sb.push_back('{0, 1'b0, 32'hDEAD_BEEF});
    look();
    chk("t1_m0_ack", m0_ack_o, 1);
    chk("t1_m1_ack", m1_ack_o, 0);
    chk("t1_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
    step();
    s_ack_i = 1'b0; s_dat_i = '0; drop_masters();
    look();
    chk("t1_busy_fall", busy_o, 0);
    chk("t1_grant_hold", grant_o, 0);

    // contention from reset with zero-wait acks
    step();
    rstn = 1'b0;
    #3 rstn = 1'b1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 39'h0_2000_0000;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 39'h0_3000_0000;
    owner = 0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) begin
        s_ack_i = 1'b1;
        s_dat_i = 32'hA000_0000 + 32'(k);
        sb.push_back('{owner, 1'b0, 32'hA000_0000 + 32'(k)});
      end else begin
        s_ack_i = 1'b0;
      end
      look();
      chk("t2_busy_pattern", busy_o, (k % 2 == 1) ? 64'd1 : 64'd0);
      if (k % 2 == 1) begin
        chk("t2_grant_order", grant_o, owner);
        chk("t2_s_adr", s_adr_o, (owner == 1) ? 39'h0_3000_0000 : 39'h0_2000_0000);
        owner = 1 - owner;
      end
      step();
    end
    s_ack_i = 1'b0; s_dat_i = '0; drop_masters();

    // m1 write pass-through
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_adr_i = 39'h0_1000_0004; m1_dat_i = 32'h1234_5678; m1_sel_i = 4'h3;
    look(); chk("t3_idle_we", s_we_o, 0);
    for (int b = 1; b <= 3; b++) begin
      step();
      if (b == 3) begin
        s_ack_i = 1'b1; s_dat_i = 32'h0000_00AA;
        sb.push_back('{1, 1'b0, 32'h0000_00AA});
      end
      look();
      chk("t3_s_we", s_we_o, 1);
      chk("t3_s_dat", s_dat_o, 32'h1234_5678);
      chk("t3_s_sel", s_sel_o, 4'h3);
      chk("t3_s_adr", s_adr_o, 39'h0_1000_0004);
    end
    chk("t3_m1_ack", m1_ack_o, 1);
    step();
    s_ack_i = 1'b0; s_dat_i = '0; drop_masters();
    look();
    chk("t3_idle_after", busy_o, 0);
    chk("t3_grant_hold", grant_o, 1);

    // timeout on m0 with m1 pending
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 39'h0_4000_0000;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 39'h0_5000_0000;
    look();
    for (int b = 1; b <= 4; b++) begin
      step();
      if (b == 4) sb.push_back('{0, 1'b1, 32'h0});
      look();
      chk("t4_busy", busy_o, 1);
      chk("t4_m0_err", m0_err_o, (b == 4) ? 64'd1 : 64'd0);
    end
    step();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    look();
    chk("t4_idle", busy_o, 0);
    chk("t4_err_once", m0_err_o, 0);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'h5555_0001;
    sb.push_back('{1, 1'b0, 32'h5555_0001});
    look();
    chk("t4_next_grant", grant_o, 1);
    chk("t4_m1_ack", m1_ack_o, 1);
    step();
    s_ack_i = 1'b0; s_dat_i = '0; drop_masters();

    // ack and timeout on the same cycle
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 39'h0_6000_0000;
    look();
    for (int b = 1; b <= 4; b++) begin
      step();
      if (b == 4) begin
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
        sb.push_back('{0, 1'b0, 32'hCAFE_F00D});
      end
      look();
    end
    chk("t5_m0_ack", m0_ack_o, 1);
    chk("t5_m0_err", m0_err_o, 0);
    step();
    s_ack_i = 1'b0; s_dat_i = '0; drop_masters();

    // abort on the 2nd BUSY cycle, then a stray ack in IDLE
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 39'h0_7000_0000;
    look();
    step(); look(); chk("t6_s_cyc_up", s_cyc_o, 1);
    step();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    look();
    chk("t6_s_cyc_drop", s_cyc_o, 0);
    chk("t6_no_resp", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hBAD0_BAD0;
    look();
    chk("t6_idle", busy_o, 0);
    chk("t6_stray_ack", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    step();
    s_ack_i = 1'b0; s_dat_i = '0;

    // asynchronous reset in the middle of a BUSY cycle
    step();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_adr_i = 39'h0_0F00_0000; m1_sel_i = 4'hF; m1_dat_i = 32'h0BAD_CAFE;
    look();
    step(); look();
    chk("t7_busy_pre", busy_o, 1);
    chk("t7_grant_pre", grant_o, 1);
    #2 rstn = 1'b0;
    #1;
    chk("t7_s_cyc", s_cyc_o, 0);
    chk("t7_s_stb_we", {s_stb_o, s_we_o}, 0);
    chk("t7_busy", busy_o, 0);
    chk("t7_grant", grant_o, 0);
    chk("t7_s_adr", s_adr_o, 0);
    chk("t7_s_dat_sel", {s_dat_o, s_sel_o}, 0);
    drop_masters();
    #1 rstn = 1'b1;
    step(); step();

    n_checks++;
    assert (sb.size() == 0)
    else begin
      n_errors++;
      $error("FAIL sb_drained: observed=%0d pending expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
Name: wb_arb

Overview:
- Two-master, one-slave Wishbone classic arbiter in front of the shared peripheral bus.
- Master 0 is the LSU router's bus port; master 1 is the instruction-fetch uncached port.
- Grants the bus with round-robin priority and holds the grant until the slave acks.
- Aborts the transaction if the owner drops cyc (flush), and returns an error to the owner if the slave never acks within a cycle budget.

Parameters:
ADDR_LEN, 39, address width (matches VIRTUAL_ADDR_LEN)
DATA_LEN, 32, Wishbone data width (matches WB_DATA_LEN); sel width is DATA_LEN/8
TIMEOUT, 255, BUSY cycles without ack before error; legal range 1..2^TO_W-1
TO_W, 8, timeout counter width

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
m0_cyc_i / m1_cyc_i  in  1  master cycle request
m0_stb_i / m1_stb_i  in  1  master strobe
m0_we_i / m1_we_i  in  1  1 = write
m0_adr_i / m1_adr_i  in  ADDR_LEN  address
m0_dat_i / m1_dat_i  in  DATA_LEN  write data
m0_sel_i / m1_sel_i  in  DATA_LEN/8  byte select
m0_ack_o / m1_ack_o  out  1  ack routed to owner
m0_err_o / m1_err_o  out  1  timeout error pulse to owner
m0_dat_o / m1_dat_o  out  DATA_LEN  read data (s_dat_i to both masters)
s_cyc_o, s_stb_o, s_we_o  out  1  slave bus controls
s_adr_o  out  ADDR_LEN  slave address
s_dat_o  out  DATA_LEN  slave write data
s_sel_o  out  DATA_LEN/8  slave byte select
s_ack_i  in  1  slave ack
s_dat_i  in  DATA_LEN  slave read data
busy_o  out  1  state == BUSY
grant_o  out  1  current or last owner index

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE, grant = 0, last = 1 (master 0 wins first), counter = 0.
  - All outputs 0.
- State IDLE:
  - All s_* outputs are 0; no ack/err to masters.
  - If any mX_cyc_i is high, the winner is registered and state goes to BUSY next cycle. One cycle of arbitration latency.
  - Winner: the only requester; if both request, the master != last.
- State BUSY:
  - s_cyc_o = own_cyc_i and s_stb_o = own_stb_i.
  - s_we_o, s_adr_o, s_dat_o, s_sel_o mux combinationally from the owner's inputs.
  - The non-owner sees ack = 0 and err = 0 and waits.
  - counter increments each BUSY cycle and clears on entry to BUSY.
- BUSY exit conditions, evaluated in priority order:
  1. s_ack_i = 1: own_ack_o = s_ack_i in the same cycle (combinational); last <= grant; state -> IDLE.
  2. own_cyc_i = 0 (abort/flush): state -> IDLE; last <= grant; no ack or err to any master; a late s_ack_i in IDLE is dropped.
  3. counter == TIMEOUT-1 with no ack: own_err_o = 1 for exactly that cycle; last <= grant; state -> IDLE.
- Ack and timeout in the same cycle: ack wins, err stays 0.
- Back-to-back transfers: after any exit the arbiter spends at least one IDLE cycle before the next grant.
  - Both masters requesting continuously therefore alternate 0,1,0,1…
  - Each transfer costs 1 IDLE cycle + (BUSY cycles until ack).
- s_ack_i while IDLE: ignored; no state change.
- grant_o holds its value in IDLE; it changes only on an IDLE->BUSY transition.
- m0_dat_o = m1_dat_o = s_dat_i, unregistered. Masters sample it only with their own ack.
- No combinational path from s_ack_i to any s_* output.

Test Plan:
- Reset then m0 single read:
  - Stimulus: m0_cyc/stb=1, adr=0x1000_0000, sel=0xF; slave acks 2 cycles after s_cyc_o rises with s_dat_i=0xDEADBEEF.
  - Required: s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o=1 with m0_dat_o=0xDEADBEEF; m1_ack_o stays 0; busy_o falls the next cycle.
- Contention:
  - Stimulus: m0 and m1 both request from reset with zero-wait acks.
  - Required: grant order 0,1,0,1; each transfer is exactly 2 cycles (IDLE + BUSY); s_adr_o alternates between the two masters' addresses.
- Write pass-through:
  - Stimulus: m1 write, adr=0x1000_0004, dat=0x12345678, sel=0x3.
  - Required: s_we_o=1, s_dat_o=0x12345678, s_sel_o=0x3 for the whole BUSY period; m1_ack_o on s_ack_i.
- Timeout:
  - Stimulus: TIMEOUT=4; m0 requests; slave never acks.
  - Required: m0_err_o pulses exactly once, on the 4th BUSY cycle; state returns to IDLE; a pending m1 request is granted next.
- Ack/timeout collision:
  - Stimulus: TIMEOUT=4; s_ack_i arrives on the 4th BUSY cycle.
  - Required: m0_ack_o=1 and m0_err_o=0.
- Abort and async reset:
  - Stimulus: m0 drops cyc on the 2nd BUSY cycle; separately, rstn is asserted mid-BUSY between clock edges.
  - Required, abort: s_cyc_o drops in the same cycle; no ack/err to either master; a later stray s_ack_i is ignored.
  - Required, reset: all outputs go to 0 immediately, without waiting for a clock edge.
